// File: rtl/console_mrdy_controller.sv
`default_nettype none
// ============================================================================
// Module   : console_mrdy_controller
// Brief    : 6809 MRDY wait-state generator stretching EEPROM and IO cycles.
// Revision : 1.0 - initial release
// ============================================================================
module console_mrdy_controller #(
    parameter int EEPROM_WAIT = 6,
    parameter int IO_WAIT     = 2,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic e,
    input  logic q,
    input  logic bus_available,
    input  logic sram_select,
    input  logic io_select,
    input  logic eeprom_select,
    output logic mrdy,
    output logic busy,
    output logic abort_flag
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_wait = 2'd1;
    localparam logic [1:0] c_hold = 2'd2;

    localparam logic [CNT_W-1:0] c_eeprom_wait = CNT_W'(EEPROM_WAIT);
    localparam logic [CNT_W-1:0] c_io_wait     = CNT_W'(IO_WAIT);
    localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);

    // Bit 0/1 synchronize, bit 2 is the previous synchronized value for edge detect
    logic [2:0]       r_q_sync;
    logic [2:0]       r_e_sync;
    logic             w_q_rise;
    logic             w_e_fall;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_wait_len;

    logic             r_mrdy;
    logic             r_busy;
    logic             r_abort;
    logic             w_mrdy_next;
    logic             w_busy_next;
    logic             w_abort_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q_sync <= 3'b000;
            r_e_sync <= 3'b000;
        end else begin
            r_q_sync <= {r_q_sync[1:0], q};
            r_e_sync <= {r_e_sync[1:0], e};
        end
    end

    assign w_q_rise = r_q_sync[1] & ~r_q_sync[2];
    assign w_e_fall = ~r_e_sync[1] & r_e_sync[2];

    // Selects only matter on the q_rise edge, so this is effectively a latch-at-q_rise
    always_comb begin
        w_wait_len = '0;
        if (bus_available) begin
            w_wait_len = '0;
        end else if (eeprom_select) begin
            w_wait_len = c_eeprom_wait;
        end else if (io_select) begin
            w_wait_len = c_io_wait;
        end else if (sram_select) begin
            w_wait_len = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_idle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            c_idle: begin
                if (w_q_rise && (w_wait_len != '0)) begin
                    w_state_next = c_wait;
                    w_cnt_next   = w_wait_len;
                end
            end
            c_wait: begin
                // Abort wins over the terminal count on the same edge
                if (w_e_fall) begin
                    w_state_next = c_idle;
                    w_cnt_next   = '0;
                end else if ((r_cnt == c_cnt_one) || (r_cnt == '0)) begin
                    w_state_next = c_hold;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt - c_cnt_one;
                end
            end
            c_hold: begin
                if (w_e_fall) begin
                    w_state_next = c_idle;
                end
            end
            default: begin
                w_state_next = c_idle;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        w_mrdy_next  = (w_state_next != c_wait);
        w_busy_next  = (w_state_next != c_idle);
        w_abort_next = r_abort | ((r_state == c_wait) & w_e_fall);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mrdy  <= 1'b1;
            r_busy  <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_mrdy  <= w_mrdy_next;
            r_busy  <= w_busy_next;
            r_abort <= w_abort_next;
        end
    end

    assign mrdy       = r_mrdy;
    assign busy       = r_busy;
    assign abort_flag = r_abort;

endmodule
`default_nettype wire
